// File: rtl/g25_pushbutton_debouncer_if.sv
// Pushbutton conditioning signals: raw keys in, debounced level, edge strobes and busy out.
interface g25_pushbutton_debouncer_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] key_raw;
   logic [WIDTH-1:0] key_db;
   logic [WIDTH-1:0] press_pulse;
   logic [WIDTH-1:0] release_pulse;
   logic             busy;

   modport master (
      output key_raw,
      input  key_db,
      input  press_pulse,
      input  release_pulse,
      input  busy
   );

   modport slave (
      input  key_raw,
      output key_db,
      output press_pulse,
      output release_pulse,
      output busy
   );
endinterface

// File: rtl/g25_pushbutton_debouncer.sv
// Two-flop synchroniser plus per-channel stability filter for active-low pushbuttons;
// emits a clean level for the PIO and one-cycle press/release strobes.
module g25_pushbutton_debouncer #(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 500000,
   parameter int CNT_W         = 20
) (
   input  logic                      clk,
   input  logic                      reset_n,
   g25_pushbutton_debouncer_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] key_db_q;
   logic [WIDTH-1:0] press_q;
   logic [WIDTH-1:0] release_q;
   logic             busy_q;
   logic [CNT_W-1:0] cnt_q   [WIDTH];

   logic [WIDTH-1:0] key_db_nxt;
   logic [WIDTH-1:0] press_nxt;
   logic [WIDTH-1:0] release_nxt;
   logic             busy_nxt;
   logic [CNT_W-1:0] cnt_nxt [WIDTH];

   // Any agreement clears the count, so a bounce gets no partial credit.
   always_comb begin
      key_db_nxt  = key_db_q;
      press_nxt   = '0;
      release_nxt = '0;
      busy_nxt    = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = '0;
         if (s2[i] != key_db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               key_db_nxt[i]  = s2[i];
               press_nxt[i]   = key_db_q[i] & ~s2[i];
               release_nxt[i] = ~key_db_q[i] & s2[i];
            end else begin
               cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
            end
         end
         busy_nxt = busy_nxt | (cnt_nxt[i] != '0);
      end
   end

   // Reset to "released" so the PIO never sees a falling edge out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1        <= '1;
         s2        <= '1;
         key_db_q  <= '1;
         press_q   <= '0;
         release_q <= '0;
         busy_q    <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1        <= bus.key_raw;
         s2        <= s1;
         key_db_q  <= key_db_nxt;
         press_q   <= press_nxt;
         release_q <= release_nxt;
         busy_q    <= busy_nxt;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_nxt[i];
         end
      end
   end

   assign bus.key_db        = key_db_q;
   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;
   assign bus.busy          = busy_q;

endmodule

// File: tb/tb_g25_pushbutton_debouncer.sv
// Scoreboard bench for g25_pushbutton_debouncer: a window-based reference model predicts
// every cycle's outputs, a negedge monitor compares them against the DUT.
module tb_g25_pushbutton_debouncer;

   localparam int W  = 4;
   localparam int S  = 8;
   localparam int CW = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   always #10 clk = ~clk;

   g25_pushbutton_debouncer_if #(.WIDTH(W)) dbif ();

   g25_pushbutton_debouncer #(
      .WIDTH(W),
      .STABLE_CYCLES(S),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(dbif)
   );

   typedef struct packed {
      logic [W-1:0] db;
      logic [W-1:0] press;
      logic [W-1:0] rel;
      logic         busy;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model state: the level, a two-entry delay for the synchroniser, and
   // the filter inputs seen since the last reset (last S of them).
   logic [W-1:0] m_db;
   logic [W-1:0] dq[$];
   logic [W-1:0] fin_q[$];
   exp_t         m_out;
   logic [W-1:0] cur_raw;
   logic         cur_rstn;

   task automatic model_reset();
      m_db  = '1;
      dq    = {4'hF, 4'hF};
      fin_q = {};
      m_out = '{db: 4'hF, press: 4'h0, rel: 4'h0, busy: 1'b0};
   endtask

   // A channel flips once its last S filter inputs all disagree with the current level.
   task automatic model_edge(input logic [W-1:0] raw);
      logic [W-1:0] fin;
      logic [W-1:0] newdb;
      logic         bsy;
      logic         all_diff;
      fin = dq.pop_front();
      dq.push_back(raw);
      fin_q.push_back(fin);
      if (fin_q.size() > S) void'(fin_q.pop_front());
      newdb = m_db;
      bsy   = 1'b0;
      for (int i = 0; i < W; i++) begin
         all_diff = (fin_q.size() == S);
         for (int k = 0; k < fin_q.size(); k++) begin
            if (fin_q[k][i] == m_db[i]) all_diff = 1'b0;
         end
         if (all_diff) newdb[i] = ~m_db[i];
         else if (fin[i] != m_db[i]) bsy = 1'b1;
      end
      m_out.press = m_db & ~newdb;
      m_out.rel   = ~m_db & newdb;
      m_out.db    = newdb;
      m_out.busy  = bsy;
      m_db        = newdb;
   endtask

   task automatic step(input logic [W-1:0] raw, input logic rstn);
      @(posedge clk);
      #1;
      if (cur_rstn) model_edge(cur_raw);
      cur_raw      = raw;
      cur_rstn     = rstn;
      dbif.key_raw = raw;
      reset_n      = rstn;
      if (!rstn) model_reset();
      exp_q.push_back(m_out);
   endtask

   task automatic hold(input logic [W-1:0] raw, input int n);
      for (int k = 0; k < n; k++) step(raw, 1'b1);
   endtask

   // Monitor: outputs are presented every cycle; compare mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      exp_t got;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = '{db: dbif.key_db, press: dbif.press_pulse, rel: dbif.release_pulse,
                 busy: dbif.busy};
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL vec%0d @%0t: got db=%h press=%h rel=%h busy=%b, required db=%h press=%h rel=%h busy=%b",
                     vectors, $time, got.db, got.press, got.rel, got.busy,
                     e.db, e.press, e.rel, e.busy);
         end
      end
   end

   initial begin
      logic [W-1:0] r;
      int           rate;
      dbif.key_raw = '1;
      cur_raw      = '1;
      cur_rstn     = 1'b0;
      model_reset();
      #2 reset_n = 1'b0;

      // Keys held through reset, then qualified as presses after release.
      for (int k = 0; k < 3; k++) step(4'h0, 1'b0);
      hold(4'h0, 14);
      hold(4'hF, 14);
      // Clean press and release on key 0.
      hold(4'hE, 14);
      hold(4'hF, 14);
      // Bounce on key 2: never holds long enough.
      hold(4'hB, 6);
      hold(4'hF, 2);
      hold(4'hB, 6);
      hold(4'hF, 12);
      // Keys 1 and 3 together.
      hold(4'h5, 14);
      hold(4'hF, 14);
      // Reset part-way through a count with key 0 held.
      hold(4'hE, 7);
      step(4'hE, 1'b0);
      step(4'hE, 1'b0);
      hold(4'hE, 14);
      hold(4'hF, 14);

      // Random phases alternating bouncy and calm keys, with rare resets.
      r = '1;
      for (int p = 0; p < 8; p++) begin
         rate = (p % 2 == 1) ? 4 : 24;
         for (int c = 0; c < 120; c++) begin
            for (int b = 0; b < W; b++) begin
               if ($urandom_range(rate - 1, 0) == 0) r[b] = ~r[b];
            end
            step(r, ($urandom_range(249, 0) != 0));
         end
      end
      hold(4'hF, 12);

      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
